// File: rtl/nor_netlist_executor_if.sv
// nor_netlist_executor_if: program write port, input/output handshakes and status of the NOR netlist executor.
// The trace signals exist only when NOR_TRACE_EN is defined.
interface nor_netlist_executor_if #(
  parameter int NUM_IN = 8,
  parameter int IDX_W  = 5,
  parameter int PC_W   = 5
);
  logic                   prog_we;
  logic [PC_W-1:0]        prog_addr;
  logic [2+3*IDX_W-1:0]   prog_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_IN-1:0]      x;
  logic [IDX_W-1:0]       out_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic                   z;
  logic                   err;
`ifdef NOR_TRACE_EN
  logic                   trc_valid;
  logic [PC_W-1:0]        trc_pc;
  logic [IDX_W-1:0]       trc_idx;
  logic                   trc_val;
  modport master (output prog_we, prog_addr, prog_data, in_valid, x, out_idx, out_ready,
                  input in_ready, out_valid, z, err, trc_valid, trc_pc, trc_idx, trc_val);
  modport slave (input prog_we, prog_addr, prog_data, in_valid, x, out_idx, out_ready,
                 output in_ready, out_valid, z, err, trc_valid, trc_pc, trc_idx, trc_val);
`else
  modport master (output prog_we, prog_addr, prog_data, in_valid, x, out_idx, out_ready,
                  input in_ready, out_valid, z, err);
  modport slave (input prog_we, prog_addr, prog_data, in_valid, x, out_idx, out_ready,
                 output in_ready, out_valid, z, err);
`endif
endinterface

// File: rtl/nor_netlist_executor.sv
// nor_netlist_executor: steps an inv1/nor2 gate program one gate per clock over a bit-node register file.
// Define NOR_TRACE_EN to add a registered per-gate trace (trc_valid/trc_pc/trc_idx/trc_val).
module nor_netlist_executor #(
  parameter int NUM_IN    = 8,
  parameter int NUM_NODES = 32,
  parameter int MAX_GATES = 32,
  parameter int IDX_W     = $clog2(NUM_NODES),
  parameter int PC_W      = $clog2(MAX_GATES)
) (
  input logic                  clk,
  input logic                  rst_n,
  nor_netlist_executor_if.slave bus
);
  localparam int DW = 2 + 3 * IDX_W;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t               r_state, w_next;
  logic [DW-1:0]        r_mem [MAX_GATES];
  logic [NUM_NODES-1:0] r_nodes;
  logic [PC_W-1:0]      r_pc;
  logic [IDX_W-1:0]     r_out_idx;
  logic                 r_z, r_err;
  logic [1:0]           w_op;
  logic [IDX_W-1:0]     w_a, w_b, w_y;
  logic w_accept, w_exec, w_gate, w_bad_y, w_wr, w_va, w_vb, w_res, w_end, w_set_err, w_z;

  // Nodes beyond the file read as constant 0.
  function automatic logic rd(input logic [NUM_NODES-1:0] n, input logic [IDX_W-1:0] i);
    return int'(i) < NUM_NODES ? n[i] : 1'b0;
  endfunction

  assign {w_op, w_a, w_b, w_y} = r_mem[r_pc];
  assign w_accept  = r_state == IDLE && bus.in_valid;
  assign w_exec    = r_state == EXEC;
  assign w_gate    = w_exec && (w_op == 2'b01 || w_op == 2'b10);
  assign w_bad_y   = int'(w_y) < NUM_IN || int'(w_y) >= NUM_NODES;
  assign w_wr      = w_gate && !w_bad_y;
  assign w_va      = rd(r_nodes, w_a);
  assign w_vb      = rd(r_nodes, w_b);
  assign w_res     = w_op[1] ? ~(w_va | w_vb) : ~w_va;
  assign w_end     = w_exec && (!w_gate || int'(r_pc) == MAX_GATES - 1);
  assign w_set_err = (bus.prog_we && r_state != IDLE) || (w_exec && w_op == 2'b11) ||
                     (w_gate && (w_bad_y || int'(w_a) >= NUM_NODES || (w_op[1] && int'(w_b) >= NUM_NODES)));
  // The last slot's own write must be visible in the result captured on the same edge.
  assign w_z       = (w_wr && w_y == r_out_idx) ? w_res : rd(r_nodes, r_out_idx);

  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.z         = r_z;
  assign bus.err       = r_err;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = EXEC;
    if (w_end) w_next = DONE;
    if (r_state == DONE && bus.out_ready) w_next = IDLE;
  end

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk)
    if (bus.prog_we && r_state == IDLE) r_mem[bus.prog_addr] <= bus.prog_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_nodes   <= '0;
      r_pc      <= '0;
      r_out_idx <= '0;
      r_z       <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_nodes[NUM_IN-1:0] <= bus.x;
        r_out_idx           <= bus.out_idx;
      end
      if (w_wr) r_nodes[w_y] <= w_res;
      r_pc <= w_accept ? '0 : w_exec ? r_pc + 1'b1 : r_pc;
      if (w_end) r_z <= w_z;
      if (w_set_err) r_err <= 1'b1;
    end

`ifdef NOR_TRACE_EN
  logic                 r_trc_valid, r_trc_val;
  logic [PC_W-1:0]      r_trc_pc;
  logic [IDX_W-1:0]     r_trc_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_trc_valid <= 1'b0;
      r_trc_pc    <= '0;
      r_trc_idx   <= '0;
      r_trc_val   <= 1'b0;
    end else begin
      r_trc_valid <= w_wr;
      r_trc_pc    <= r_pc;
      r_trc_idx   <= w_y;
      r_trc_val   <= w_res;
    end
  assign bus.trc_valid = r_trc_valid;
  assign bus.trc_pc    = r_trc_pc;
  assign bus.trc_idx   = r_trc_idx;
  assign bus.trc_val   = r_trc_val;
`endif
endmodule

// File: tb/tb_nor_netlist_executor.sv
// tb_nor_netlist_executor: table vectors, random programs against a gate-list model,
// plus hold, mid-run reset, program-write-while-busy, no-END and bad-destination sequences.
module tb_nor_netlist_executor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int m_op [32];
  int m_a [32];
  int m_b [32];
  int m_y [32];
  bit [31:0] m_nodes;
  bit m_err;

  nor_netlist_executor_if #(.NUM_IN(8), .IDX_W(5), .PC_W(5)) bus ();
  nor_netlist_executor #(.NUM_IN(8), .NUM_NODES(32), .MAX_GATES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int         prog;
    logic [7:0] x;
    int         oi;
    bit         z;
    int         lat;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Gate list interpreted in order: a gate sees everything written before it.
  task automatic model(input logic [7:0] x, input int oi, output bit z, output int lat);
    int steps;
    bit va, vb, r;
    steps = 0;
    lat = -1;
    m_nodes[7:0] = x;
    for (int pc = 0; pc < 32; pc++) begin
      if (m_op[pc] == 0 || m_op[pc] == 3) begin
        if (m_op[pc] == 3) m_err = 1;
        lat = steps + 1;
        break;
      end
      va = m_nodes[m_a[pc]];
      vb = m_nodes[m_b[pc]];
      r = (m_op[pc] == 1) ? !va : !(va || vb);
      if (m_y[pc] < 8) m_err = 1;
      else m_nodes[m_y[pc]] = r;
      steps++;
    end
    if (lat < 0) lat = steps;
    z = m_nodes[oi];
  endtask

  task automatic wr(input int s, input int op, input int a, input int b, input int y, input bit take);
    @(negedge clk);
    bus.prog_we = 1'b1;
    bus.prog_addr = s[4:0];
    bus.prog_data = {op[1:0], a[4:0], b[4:0], y[4:0]};
    @(negedge clk);
    bus.prog_we = 1'b0;
    if (take) begin
      m_op[s] = op; m_a[s] = a; m_b[s] = b; m_y[s] = y;
    end else m_err = 1;
  endtask

  task automatic start(input logic [7:0] x, input int oi);
    @(negedge clk);
    bus.x = x;
    bus.out_idx = oi[4:0];
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: out_valid still %0d after %0d cycles, expected 1", bus.out_valid, lat);
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic run(input logic [7:0] x, input int oi, output bit gz, output int glat);
    bit mz;
    int mlat;
    model(x, oi, mz, mlat);
    start(x, oi);
    wait_done(glat);
    gz = bus.z;
    chk("z", gz, mz);
    chk("latency", glat, mlat);
    chk("err", bus.err, m_err);
    handshake();
  endtask

  initial begin
    bit gz, mz;
    int gl, mlat, cur, len;
    logic [7:0] xr;
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
    bus.in_valid = 0; bus.x = 0; bus.out_idx = 0; bus.out_ready = 0;
    m_nodes = 0; m_err = 0;
    tbl[0] = '{0, 8'h02, 8, 1'b0, 2};
    tbl[1] = '{0, 8'h00, 8, 1'b1, 2};
    tbl[2] = '{0, 8'hFF, 8, 1'b0, 2};
    tbl[3] = '{0, 8'hFD, 8, 1'b1, 2};
    tbl[4] = '{1, 8'h01, 10, 1'b1, 3};
    tbl[5] = '{1, 8'h00, 10, 1'b0, 3};
    tbl[6] = '{1, 8'h08, 10, 1'b1, 3};
    tbl[7] = '{1, 8'hF6, 10, 1'b0, 3};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;

    cur = -1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].prog != cur) begin
        cur = tbl[i].prog;
        if (cur == 0) begin
          wr(0, 1, 1, 0, 8, 1); wr(1, 0, 0, 0, 0, 1);
        end else begin
          wr(0, 2, 0, 3, 9, 1); wr(1, 1, 9, 0, 10, 1); wr(2, 0, 0, 0, 0, 1);
        end
      end
      run(tbl[i].x, tbl[i].oi, gz, gl);
      chk("tbl_z", gz, tbl[i].z);
      chk("tbl_lat", gl, tbl[i].lat);
    end

    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 20);
      for (int g = 0; g < len; g++)
        wr(g, $urandom_range(1, 2), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(8, 31), 1);
      wr(len, 0, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) run(8'($urandom), $urandom_range(0, 31), gz, gl);
    end

    // 20-inverter chain: node 27 ends up equal to x[0].
    for (int i = 0; i < 20; i++) wr(i, 1, (i == 0) ? 0 : 7 + i, 0, 8 + i, 1);
    wr(20, 0, 0, 0, 0, 1);
    model(8'h01, 27, mz, mlat);
    start(8'h01, 27);
    wait_done(gl);
    chk("chain_z", bus.z, 1);
    chk("chain_model_z", bus.z, mz);
    chk("chain_lat", gl, 21);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_z", bus.z, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    handshake();

    start(8'h00, 27);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_in_ready", bus.in_ready, 1);
    chk("async_z", bus.z, 0);
    m_nodes = 0;
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(8'hFF, 27, gz, gl);
    chk("rerun_z", gz, 1);

    model(8'h01, 27, mz, mlat);
    start(8'h01, 27);
    wr(0, 1, 5, 0, 27, 0);
    wait_done(gl);
    chk("busy_write_z", bus.z, mz);
    chk("busy_write_err", bus.err, 1);
    handshake();
    run(8'h00, 27, gz, gl);
    chk("slot_kept_z", gz, 0);
    chk("err_sticky", bus.err, 1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_nodes = 0;
    m_err = 0;
    chk("err_cleared", bus.err, 0);
    for (int i = 0; i < 32; i++)
      wr(i, 2, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(8, 31), 1);
    run(8'($urandom), $urandom_range(0, 31), gz, gl);
    chk("no_end_lat", gl, 32);
    chk("no_end_err", bus.err, 0);
    wr(5, 2, $urandom_range(0, 31), $urandom_range(0, 31), 3, 1);
    xr = 8'($urandom);
    run(xr, 3, gz, gl);
    chk("dest_guard_z", gz, xr[3]);
    chk("dest_guard_err", bus.err, 1);
    wr(0, 3, 0, 0, 9, 1);
    run(8'($urandom), 9, gz, gl);
    chk("reserved_lat", gl, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
